// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: scheduler state encoding
// and default widths.
package uart_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_GAP_WIDTH    = 4;
    localparam int DEF_CNT_WIDTH    = 16;
    localparam int DEF_BUSY_TIMEOUT = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_POP       = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5
    } tx_state_e;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_tx_sched_gap_timer.sv
// Load/decrement down-counter shared by the busy timeout and the inter-frame gap.
// 'last' flags that the current decrement takes the count to zero.
module gap_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    // Next count: a load wins over a decrement; the count never goes below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q <= WIDTH'(1));

endmodule

// File: rtl/fifo_tx_sched.sv
// Read-side scheduler: pops one FIFO word, launches it to the UART transmitter,
// waits for the frame to finish, then holds off for the configured gap.
module fifo_tx_sched
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int GAP_WIDTH    = DEF_GAP_WIDTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic [GAP_WIDTH-1:0]  GAP_CFG,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  R_INC,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    output logic [CNT_WIDTH-1:0]  SENT_CNT,
    output logic                  TX_ERR,
    output logic                  ACTIVE
);

    localparam int TMR_WIDTH = max_width(GAP_WIDTH, $clog2(BUSY_TIMEOUT + 1));

    tx_state_e             state_d, state_q;
    logic [DATA_WIDTH-1:0] hold_d, hold_q;
    logic [DATA_WIDTH-1:0] tx_data_d, tx_data_q;
    logic [CNT_WIDTH-1:0]  sent_d, sent_q;
    logic                  r_inc_d, r_inc_q;
    logic                  valid_d, valid_q;
    logic                  err_d, err_q;
    logic                  active_d, active_q;

    logic                  tmr_load_s;
    logic [TMR_WIDTH-1:0]  tmr_val_s;
    logic                  tmr_dec_s;
    logic                  tmr_last_s;

    gap_timer #(
        .WIDTH    (TMR_WIDTH)
    ) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .dec      (tmr_dec_s),
        .last     (tmr_last_s)
    );

    // Next-state and next-output logic for the pop/launch/wait/gap sequence.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        tx_data_d  = tx_data_q;
        sent_d     = sent_q;
        r_inc_d    = 1'b0;
        valid_d    = 1'b0;
        err_d      = err_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        tmr_dec_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ENABLE && !EMPTY && !TX_BUSY) begin
                    hold_d  = RD_DATA;
                    r_inc_d = 1'b1;
                    state_d = ST_POP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP: begin
                tx_data_d = hold_q;
                valid_d   = 1'b1;
                state_d   = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                tmr_load_s = 1'b1;
                tmr_val_s  = TMR_WIDTH'(BUSY_TIMEOUT);
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    tmr_dec_s = 1'b1;
                    // Transmitter never acknowledged: the word is dropped uncounted.
                    if (tmr_last_s) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_BUSY;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!TX_BUSY) begin
                    sent_d = sent_q + CNT_WIDTH'(1);
                    if (GAP_CFG == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmr_load_s = 1'b1;
                        tmr_val_s  = TMR_WIDTH'(GAP_CFG);
                        state_d    = ST_GAP;
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                tmr_dec_s = 1'b1;
                if (tmr_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        active_d = (state_d != ST_IDLE);
    end

    // State, data and status registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            tx_data_q <= '0;
            sent_q    <= '0;
            r_inc_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            tx_data_q <= tx_data_d;
            sent_q    <= sent_d;
            r_inc_q   <= r_inc_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            active_q  <= active_d;
        end
    end

    assign R_INC         = r_inc_q;
    assign TX_P_DATA     = tx_data_q;
    assign TX_DATA_VALID = valid_q;
    assign SENT_CNT      = sent_q;
    assign TX_ERR        = err_q;
    assign ACTIVE        = active_q;

endmodule

// File: tb/tb_fifo_tx_sched.sv
// Directed bench for fifo_tx_sched with a FWFT FIFO model and a UART transmitter model.
module tb_fifo_tx_sched;

    localparam int DW = 8;
    localparam int GW = 4;
    localparam int CW = 4;

    logic          CLK     = 1'b0;
    logic          RST     = 1'b1;
    logic          ENABLE  = 1'b0;
    logic [GW-1:0] GAP_CFG = '0;
    logic          EMPTY   = 1'b1;
    logic [DW-1:0] RD_DATA = '0;
    logic          TX_BUSY = 1'b0;
    logic          R_INC;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_DATA_VALID;
    logic [CW-1:0] SENT_CNT;
    logic          TX_ERR;
    logic          ACTIVE;

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO contents written by the stimulus, consumed by the model
    logic [DW-1:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;

    // Transmitter model controls
    int tx_respond = 1;
    int busy_len   = 10;

    // Monitor records
    int cyc = 0;
    int pops = 0;
    int under = 0;
    int rinc_cyc = 0;
    int valid_cyc = 0;
    int busy_rem = 0;
    int fall_cyc = 0;
    logic have_fall = 1'b0;
    int gaps [64];
    int gap_n = 0;
    logic [DW-1:0] log_mem [64];
    int log_n = 0;
    logic err_seen = 1'b0;
    int err_cyc = 0;

    always #5 CLK = ~CLK;

    fifo_tx_sched #(
        .DATA_WIDTH    (DW),
        .GAP_WIDTH     (GW),
        .CNT_WIDTH     (CW),
        .BUSY_TIMEOUT  (3)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .ENABLE        (ENABLE),
        .GAP_CFG       (GAP_CFG),
        .EMPTY         (EMPTY),
        .RD_DATA       (RD_DATA),
        .R_INC         (R_INC),
        .TX_BUSY       (TX_BUSY),
        .TX_P_DATA     (TX_P_DATA),
        .TX_DATA_VALID (TX_DATA_VALID),
        .SENT_CNT      (SENT_CNT),
        .TX_ERR        (TX_ERR),
        .ACTIVE        (ACTIVE)
    );

    // FIFO, transmitter and event-timing models
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (R_INC) begin
            pops     <= pops + 1;
            rinc_cyc <= cyc;
            if (have_fall) begin
                gaps[gap_n & 63] <= cyc - 1 - fall_cyc;
                gap_n <= gap_n + 1;
            end
        end
        if (R_INC && (rd_ptr != wr_ptr)) begin
            rd_ptr  <= rd_ptr + 1;
            EMPTY   <= ((rd_ptr + 1) == wr_ptr);
            RD_DATA <= mem[(rd_ptr + 1) & 63];
        end else begin
            if (R_INC) under <= under + 1;
            EMPTY   <= (rd_ptr == wr_ptr);
            RD_DATA <= mem[rd_ptr & 63];
        end
        if (TX_DATA_VALID) begin
            log_mem[log_n & 63] <= TX_P_DATA;
            log_n     <= log_n + 1;
            valid_cyc <= cyc;
            if (tx_respond != 0) begin
                TX_BUSY  <= 1'b1;
                busy_rem <= busy_len;
            end
        end else if (busy_rem > 1) begin
            busy_rem <= busy_rem - 1;
        end else if (busy_rem == 1) begin
            busy_rem  <= 0;
            TX_BUSY   <= 1'b0;
            fall_cyc  <= cyc;
            have_fall <= 1'b1;
        end
        if (TX_ERR && !err_seen) begin
            err_seen <= 1'b1;
            err_cyc  <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr & 63] = d;
        wr_ptr++;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!TX_BUSY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 32'(TX_BUSY), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rinc"},   32'(R_INC),         32'd0);
        chk({tag, "_valid"},  32'(TX_DATA_VALID), 32'd0);
        chk({tag, "_pdata"},  32'(TX_P_DATA),     32'd0);
        chk({tag, "_sent"},   32'(SENT_CNT),      32'd0);
        chk({tag, "_err"},    32'(TX_ERR),        32'd0);
        chk({tag, "_active"}, 32'(ACTIVE),        32'd0);
    endtask

    initial begin
        int p0;
        int l0;
        int g0;

        cycles(3);
        chk_reset_vals("rst");
        RST = 1'b0;
        ENABLE = 1'b1;
        cycles(2);

        // Basic single frame
        p0 = pops;
        push(8'hA5);
        cycles(40);
        chk("basic_pops",    32'(pops - p0),             32'd1);
        chk("basic_nlaunch", 32'(log_n),                 32'd1);
        chk("basic_word",    32'(log_mem[0]),            32'hA5);
        chk("basic_pdata",   32'(TX_P_DATA),             32'hA5);
        chk("basic_sent",    32'(SENT_CNT),              32'd1);
        chk("basic_empty",   32'(EMPTY),                 32'd1);
        chk("basic_active",  32'(ACTIVE),                32'd0);
        chk("basic_latency", 32'(valid_cyc - rinc_cyc),  32'd1);

        // Burst with a 5-cycle gap
        GAP_CFG = 4'd5;
        busy_len = 4;
        l0 = log_n;
        g0 = gap_n;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        cycles(120);
        chk("burst_nlaunch", 32'(log_n - l0),        32'd3);
        chk("burst_w0",      32'(log_mem[l0]),       32'h11);
        chk("burst_w1",      32'(log_mem[l0 + 1]),   32'h22);
        chk("burst_w2",      32'(log_mem[l0 + 2]),   32'h33);
        chk("burst_sent",    32'(SENT_CNT),          32'd4);
        chk("burst_ngaps",   32'(gap_n - g0),        32'd3);
        chk("burst_gap1",    32'(gaps[g0 + 1]),      32'd7);
        chk("burst_gap2",    32'(gaps[g0 + 2]),      32'd7);

        // Busy timeout
        GAP_CFG = 4'd0;
        tx_respond = 0;
        p0 = pops;
        push(8'h5A);
        cycles(30);
        chk("to_err",     32'(TX_ERR),              32'd1);
        chk("to_timing",  32'(err_cyc - valid_cyc), 32'd4);
        chk("to_sent",    32'(SENT_CNT),            32'd4);
        chk("to_pops",    32'(pops - p0),           32'd1);
        chk("to_empty",   32'(EMPTY),               32'd1);
        chk("to_active",  32'(ACTIVE),              32'd0);
        tx_respond = 1;
        push(8'h66);
        cycles(40);
        chk("to_sticky",  32'(TX_ERR),              32'd1);
        chk("to_sent2",   32'(SENT_CNT),            32'd5);
        chk("to_word2",   32'(log_mem[log_n - 1]),  32'h66);

        // Enable drop during WAIT_DONE
        busy_len = 6;
        p0 = pops;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        wait_busy("en_busy_wait");
        cycles(2);
        ENABLE = 1'b0;
        cycles(40);
        chk("en_pops",    32'(pops - p0),           32'd1);
        chk("en_sent",    32'(SENT_CNT),            32'd6);
        chk("en_left",    32'(wr_ptr - rd_ptr),     32'd2);
        chk("en_active",  32'(ACTIVE),              32'd0);
        ENABLE = 1'b1;
        cycles(60);
        chk("en_pops2",   32'(pops - p0),           32'd3);
        chk("en_sent2",   32'(SENT_CNT),            32'd8);
        chk("en_w1",      32'(log_mem[log_n - 2]),  32'h32);
        chk("en_w2",      32'(log_mem[log_n - 1]),  32'h33);

        // Reset mid-frame
        busy_len = 8;
        push(8'h77);
        wait_busy("mr_busy_wait");
        cycles(2);
        RST = 1'b1;
        #1;
        chk_reset_vals("mr");
        cycles(2);
        RST = 1'b0;
        cycles(15);
        chk("mr_empty",   32'(EMPTY),               32'd1);
        push(8'h88);
        cycles(40);
        chk("mr_sent",    32'(SENT_CNT),            32'd1);
        chk("mr_word",    32'(log_mem[log_n - 1]),  32'h88);
        chk("mr_pdata",   32'(TX_P_DATA),           32'h88);

        // Counter wrap: 16 frames return to 0, the 17th gives 1
        @(negedge CLK);
        RST = 1'b1;
        cycles(2);
        RST = 1'b0;
        busy_len = 2;
        p0 = pops;
        for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
        cycles(300);
        chk("wrap_pops16", 32'(pops - p0),          32'd16);
        chk("wrap_sent16", 32'(SENT_CNT),           32'd0);
        push(8'hD0);
        cycles(30);
        chk("wrap_sent17", 32'(SENT_CNT),           32'd1);
        chk("wrap_last",   32'(log_mem[log_n - 1]), 32'hD0);

        // Empty FIFO stays quiet
        p0 = pops;
        cycles(50);
        chk("idle_pops",   32'(pops - p0),          32'd0);
        chk("underflow",   32'(under),              32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
